// File: rtl/test_sequencer.sv
// Sequences a bank of self-checking fixtures one at a time after a settle delay,
// stopping at the first error or timeout and reporting one aggregated status.
module test_sequencer #(
  parameter int N_TESTS = 4,
  parameter int SETTLE  = 63,
  parameter int TIMEOUT = 1048576,
  parameter int IDX_W   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_restart,
  input  logic [N_TESTS-1:0] i_running,
  input  logic [N_TESTS-1:0] i_passed,
  input  logic [N_TESTS-1:0] i_error,
  output logic [N_TESTS-1:0] o_en,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_running,
  output logic               o_passed,
  output logic               o_error,
  output logic               o_timeout
);

  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int TIM_W = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE);
  localparam logic [TIM_W-1:0] TIM_LAST   = TIM_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_TESTS - 1);

  typedef enum logic [2:0] {
    S_SETTLE,
    S_RUN,
    S_GAP,
    S_PASS,
    S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TIM_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_TESTS-1:0] en_q, en_d;
  logic               running_q, running_d;
  logic               passed_q, passed_d;
  logic               error_q, error_d;
  logic               timeout_q, timeout_d;

  logic curPass;
  logic curErr;
  logic sampleOk;
  logic unusedRunning;

  // Fixture run status is advisory only.
  assign unusedRunning = ^i_running;

  // In RUN en_q is exactly one-hot at idx_q, so masking selects the current fixture.
  assign curPass  = |(i_passed & en_q);
  assign curErr   = |(i_error & en_q);
  assign sampleOk = (timer_q != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;

    case (state_q)
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
          idx_d   = '0;
          timer_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RUN: begin
        if (sampleOk && curErr) begin
          state_d   = S_FAIL;
          timeout_d = 1'b0;
        end else if (sampleOk && curPass) begin
          state_d = (idx_q == IDX_LAST) ? S_PASS : S_GAP;
        end else if (timer_q == TIM_LAST) begin
          state_d   = S_FAIL;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TIM_W'(1);
        end
      end
      S_GAP: begin
        state_d = S_RUN;
        idx_d   = idx_q + IDX_W'(1);
        timer_d = '0;
      end
      S_PASS, S_FAIL: begin
        if (i_restart) begin
          state_d   = S_SETTLE;
          cnt_d     = CNT_RELOAD;
          idx_d     = '0;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = S_SETTLE;
        cnt_d   = CNT_RELOAD;
        idx_d   = '0;
      end
    endcase

    en_d = '0;
    for (int i = 0; i < N_TESTS; i++) begin
      en_d[i] = (state_d == S_RUN) && (idx_d == IDX_W'(i));
    end
    passed_d  = (state_d == S_PASS);
    error_d   = (state_d == S_FAIL);
    running_d = !((state_d == S_PASS) || (state_d == S_FAIL));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_SETTLE;
      cnt_q     <= CNT_RELOAD;
      timer_q   <= '0;
      idx_q     <= '0;
      en_q      <= '0;
      running_q <= 1'b1;
      passed_q  <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      en_q      <= en_d;
      running_q <= running_d;
      passed_q  <= passed_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_en      = en_q;
  assign o_idx     = idx_q;
  assign o_running = running_q;
  assign o_passed  = passed_q;
  assign o_error   = error_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: a per-scenario schedule of enable windows is derived
// arithmetically from fixture outcomes/latencies and compared cycle by cycle.
module tb_test_sequencer;

  localparam int N  = 4;
  localparam int S  = 3;
  localparam int T  = 16;
  localparam int IW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_restart = 1'b0;
  logic [N-1:0]  i_running = '0;
  logic [N-1:0]  i_passed = '0;
  logic [N-1:0]  i_error = '0;
  logic [N-1:0]  o_en;
  logic [IW-1:0] o_idx;
  logic          o_running;
  logic          o_passed;
  logic          o_error;
  logic          o_timeout;

  always #5 i_clk = ~i_clk;

  test_sequencer #(
    .N_TESTS(N),
    .SETTLE (S),
    .TIMEOUT(T),
    .IDX_W  (IW)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_restart(i_restart),
    .i_running(i_running),
    .i_passed (i_passed),
    .i_error  (i_error),
    .o_en     (o_en),
    .o_idx    (o_idx),
    .o_running(o_running),
    .o_passed (o_passed),
    .o_error  (o_error),
    .o_timeout(o_timeout)
  );

  typedef enum int {OC_PASS, OC_ERR, OC_BOTH, OC_HANG} outcome_t;

  outcome_t outcome[N];
  int       delay[N];
  int       startEdge[N];
  int       runLen[N];
  int       lastFix;
  int       finalEdge;
  bit       staleMode = 1'b0;
  int       checks = 0;
  int       errors = 0;

  // Interval n is the time after clock edge n counted from reset release (or restart).
  function automatic void buildSchedule();
    lastFix = N - 1;
    for (int i = 0; i < N; i++) begin
      runLen[i] = (outcome[i] == OC_HANG) ? T - 1 : delay[i];
      startEdge[i] = (i == 0) ? S + 1 : startEdge[i-1] + runLen[i-1] + 2;
      if (outcome[i] != OC_PASS) begin
        lastFix = i;
        break;
      end
    end
    finalEdge = startEdge[lastFix] + runLen[lastFix] + 1;
  endfunction

  task automatic modelAt(input int n, output logic [N-1:0] en, output int idx,
                         output bit run, output bit pas, output bit err, output bit to,
                         output int act, output int k);
    en = '0; idx = 0; run = 1'b1; pas = 1'b0; err = 1'b0; to = 1'b0; act = -1; k = -1;
    if (n >= finalEdge) begin
      idx = lastFix;
      run = 1'b0;
      if (outcome[lastFix] == OC_PASS) pas = 1'b1;
      else begin
        err = 1'b1;
        to  = (outcome[lastFix] == OC_HANG);
      end
    end else begin
      for (int i = 0; i <= lastFix; i++) begin
        if (n >= startEdge[i] && n <= startEdge[i] + runLen[i]) begin
          en[i] = 1'b1; idx = i; act = i; k = n - startEdge[i];
        end else if (n == startEdge[i] + runLen[i] + 1) begin
          idx = i;
        end
      end
    end
  endtask

  task automatic checkVal(input string tag, input int n, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s n=%0d observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic checkOutput(input int n);
    logic [N-1:0] expEn;
    int expIdx, act, k;
    bit run, pas, err, to;
    modelAt(n, expEn, expIdx, run, pas, err, to, act, k);
    checkVal("en",      n, 32'(o_en),      32'(expEn));
    checkVal("idx",     n, 32'(o_idx),     32'(expIdx));
    checkVal("running", n, 32'(o_running), 32'(run));
    checkVal("passed",  n, 32'(o_passed),  32'(pas));
    checkVal("error",   n, 32'(o_error),   32'(err));
    checkVal("timeout", n, 32'(o_timeout), 32'(to));
    checkVal("inv_onehot",  n, 32'($onehot0(o_en)),            32'(1));
    checkVal("inv_exclude", n, 32'(o_passed & o_error),        32'(0));
    checkVal("inv_running", n, 32'(o_running ^ (o_passed | o_error)), 32'(1));
  endtask

  // Random noise everywhere except the current fixture's status bits after its entry cycle.
  task automatic applyStimulus(input int n, input bit doRestart);
    logic [N-1:0] expEn, pv, ev;
    int expIdx, act, k;
    bit run, pas, err, to;
    modelAt(n, expEn, expIdx, run, pas, err, to, act, k);
    pv = N'($urandom);
    ev = N'($urandom);
    if (act >= 0 && k >= 1) begin
      pv[act] = 1'b0;
      ev[act] = 1'b0;
      if (k == runLen[act]) begin
        case (outcome[act])
          OC_PASS: pv[act] = 1'b1;
          OC_ERR:  ev[act] = 1'b1;
          OC_BOTH: begin pv[act] = 1'b1; ev[act] = 1'b1; end
          default: ;
        endcase
      end
    end
    if (staleMode && n <= startEdge[0]) begin
      pv[0] = 1'b1;
      ev[0] = 1'b0;
    end
    i_passed  = pv;
    i_error   = ev;
    i_running = N'($urandom);
    i_restart = (n >= finalEdge) ? doRestart : 1'($urandom_range(0, 1));
  endtask

  task automatic runScenario(input bit restartAtEnd, input int stopAt);
    buildSchedule();
    for (int n = 0; n <= finalEdge + 2; n++) begin
      checkOutput(n);
      if (n == stopAt) return;
      applyStimulus(n, restartAtEnd && (n == finalEdge + 2));
      @(negedge i_clk);
    end
  endtask

  // Reset is asserted between edges so its effect must be asynchronous.
  task automatic doReset();
    logic [N-1:0] pv;
    pv = N'($urandom);
    if (staleMode) pv[0] = 1'b1;
    i_passed  = pv;
    i_error   = '0;
    i_restart = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    checkVal("rst_en",      -1, 32'(o_en),      32'(0));
    checkVal("rst_idx",     -1, 32'(o_idx),     32'(0));
    checkVal("rst_running", -1, 32'(o_running), 32'(1));
    checkVal("rst_passed",  -1, 32'(o_passed),  32'(0));
    checkVal("rst_error",   -1, 32'(o_error),   32'(0));
    checkVal("rst_timeout", -1, 32'(o_timeout), 32'(0));
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    @(negedge i_clk);

    $display("[TB] all fixtures pass, then restart repeats the sequence");
    outcome = '{OC_PASS, OC_PASS, OC_PASS, OC_PASS};
    delay   = '{5, 5, 5, 5};
    doReset();
    runScenario(1'b1, -1);
    runScenario(1'b0, -1);

    $display("[TB] error on fixture 2");
    outcome = '{OC_PASS, OC_PASS, OC_ERR, OC_PASS};
    delay   = '{5, 3, 2, 4};
    doReset();
    runScenario(1'b0, -1);

    $display("[TB] timeout on fixture 1");
    outcome = '{OC_PASS, OC_HANG, OC_PASS, OC_PASS};
    delay   = '{4, 1, 1, 1};
    doReset();
    runScenario(1'b0, -1);

    $display("[TB] passed and error together on fixture 0");
    outcome = '{OC_BOTH, OC_PASS, OC_PASS, OC_PASS};
    delay   = '{3, 1, 1, 1};
    doReset();
    runScenario(1'b0, -1);

    $display("[TB] completion on the last timer cycle");
    outcome = '{OC_PASS, OC_ERR, OC_PASS, OC_PASS};
    delay   = '{T - 1, T - 1, 1, 1};
    doReset();
    runScenario(1'b0, -1);

    $display("[TB] stale passed on fixture 0 held from reset");
    staleMode = 1'b1;
    outcome = '{OC_PASS, OC_PASS, OC_PASS, OC_PASS};
    delay   = '{1, 2, 1, 3};
    buildSchedule();
    doReset();
    runScenario(1'b0, -1);
    staleMode = 1'b0;

    $display("[TB] reset in the middle of fixture 2");
    outcome = '{OC_PASS, OC_PASS, OC_PASS, OC_PASS};
    delay   = '{4, 4, 4, 4};
    buildSchedule();
    doReset();
    runScenario(1'b0, startEdge[2] + 1);
    doReset();
    runScenario(1'b0, -1);

    $display("[TB] randomized scenarios chained by restart");
    doReset();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        int pick;
        pick = $urandom_range(0, 9);
        outcome[i] = (pick < 6) ? OC_PASS : (pick == 6) ? OC_ERR :
                     (pick == 7) ? OC_BOTH : OC_HANG;
        delay[i] = $urandom_range(1, T - 1);
      end
      runScenario(r < 5, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
Controller that runs a fixed bank of self-checking test fixtures (the alloc_test style: i_en in; o_running/o_passed/o_error out) one at a time on the Fomu bench. It waits a settle period after reset, enables each fixture in turn, and stops at the first failure or timeout. It presents one aggregated running/passed/error status for the top level to drive onto the RGB LED. It replaces the single hard-wired fixture and its ad-hoc settle counter in the bench top.

Parameters:
N_TESTS, 4, number of fixtures sequenced (1..16)
SETTLE, 63, cycles to wait after reset before enabling fixture 0 (0 allowed)
TIMEOUT, 1048576, max cycles a fixture may run before being declared failed (>=2)
IDX_W, 4, width of index outputs; must satisfy 2**IDX_W >= N_TESTS

Ports:
i_clk  in  1  system clock (48 MHz)
i_rst  in  1  asynchronous, active-high reset
i_restart  in  1  single-cycle pulse; rerun the whole sequence, honoured only in PASS/FAIL
i_running  in  N_TESTS  per-fixture o_running
i_passed  in  N_TESTS  per-fixture o_passed
i_error  in  N_TESTS  per-fixture o_error
o_en  out  N_TESTS  per-fixture enable, one-hot or zero, registered
o_idx  out  IDX_W  index of current, last, or failing fixture
o_running  out  1  high until PASS or FAIL is reached
o_passed  out  1  high in PASS only
o_error  out  1  high in FAIL only
o_timeout  out  1  high in FAIL when the cause was timeout

Behaviour:
- Reset (async, i_rst=1): state=SETTLE, settle counter=SETTLE, o_en=0, o_idx=0, o_running=1, o_passed=0, o_error=0, o_timeout=0. Reset mid-run drops o_en immediately and restarts from SETTLE.
- All outputs registered. No combinational path from any input to any output.
- SETTLE: decrement counter each cycle. The cycle it reads 0: go to RUN, idx=0, o_en[0]=1 from the next edge. SETTLE=0 means RUN on the first clock after reset release.
- RUN: o_en[idx]=1, all other bits 0. The timer clears on entry and increments each cycle.
  - Completion inputs are ignored on the entry cycle, so stale status from a just-enabled fixture is not accepted. They are sampled from the second RUN cycle on.
  - Only bit idx of i_passed/i_error is examined. Other bits and i_running are ignored; i_running is advisory only.
  - i_error[idx]=1 -> FAIL, o_timeout=0. Error wins if i_passed[idx] is high in the same cycle.
  - i_passed[idx]=1, error low, idx<N_TESTS-1 -> GAP.
  - i_passed[idx]=1, error low, idx=N_TESTS-1 -> PASS.
  - Timer reaches TIMEOUT-1 with no completion -> FAIL, o_timeout=1. Same-cycle completion takes priority over timeout.
- GAP: exactly 1 cycle with o_en=0, so each fixture sees a fresh rising enable. Then idx=idx+1 -> RUN.
- PASS: o_en=0, o_running=0, o_passed=1, o_idx=N_TESTS-1.
- FAIL: o_en=0, o_running=0, o_error=1, o_idx frozen at the failing index, o_timeout set as above.
- i_restart=1 in PASS/FAIL -> SETTLE with reload, all flags cleared, idx=0. i_restart is ignored in SETTLE/RUN/GAP.
- Width rules:
  - The timer is wide enough for TIMEOUT-1 and never wraps.
  - The settle counter is wide enough for SETTLE.
  - idx never exceeds N_TESTS-1.
- Invariants checked by the bench:
  - o_en is zero or one-hot.
  - o_passed and o_error are never both high.
  - o_running equals !(o_passed|o_error).

Test Plan:
- All pass, N_TESTS=4, SETTLE=3: each fixture asserts passed 5 cycles after en -> o_en 0001,0010,0100,1000, each separated by a 1-cycle zero gap; first en 4 cycles after reset release; final o_passed=1, o_running=0, o_idx=3.
- Error on fixture 2: i_error[2] pulses in its 3rd RUN cycle -> FAIL next edge, o_error=1, o_idx=2, o_timeout=0, o_en=0; fixture 3 is never enabled.
- Timeout with TIMEOUT=16: fixture 1 never completes -> FAIL exactly 16 cycles after o_en[1] rises, o_timeout=1, o_idx=1.
- Priorities:
  - i_passed[0] and i_error[0] high in the same cycle -> FAIL, idx 0.
  - Completion on the timer's last cycle -> treated as completion, o_timeout=0.
  - Stale i_passed[0] held high from reset -> ignored on the entry cycle, accepted on the second RUN cycle.
- Reset mid-RUN of fixture 2 -> o_en=0 asynchronously, o_running=1, flags clear; the sequence reruns from SETTLE and fixture 0.
- i_restart pulsed in RUN -> no effect. i_restart pulsed in PASS -> SETTLE reload, o_passed=0, full sequence repeats with an identical o_en pattern.
